// File: rtl/ddr3_avl_arbiter.sv
// N-channel round-robin front end for the single DDR3 Avalon-MM port: burst-locked
// grants, one read command per grant, and in-order routing of read returns via a tag FIFO.
module ddr3_avl_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 128,
    parameter int SIZE_W    = 3,
    parameter int TAG_DEPTH = 16
) (
    input  logic                       ddr3_clk,
    input  logic                       ddr3_reset_n,
    input  logic [NUM_CH-1:0]          ch_read_req,
    input  logic [NUM_CH-1:0]          ch_write_req,
    input  logic [NUM_CH-1:0]          ch_burstbegin,
    input  logic [NUM_CH*SIZE_W-1:0]   ch_size,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wr_data,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic [NUM_CH-1:0]          ch_read_data_valid,
    output logic [DATA_W-1:0]          ch_read_data,
    input  logic                       ddr3_avl_ready,
    output logic                       ddr3_avl_burstbegin,
    output logic [SIZE_W-1:0]          ddr3_avl_size,
    output logic                       ddr3_avl_read_req,
    output logic                       ddr3_avl_write_req,
    output logic [ADDR_W-1:0]          ddr3_avl_addr,
    output logic [DATA_W-1:0]          ddr3_avl_wr_data,
    input  logic                       ddr3_avl_read_data_valid,
    input  logic [DATA_W-1:0]          ddr3_avl_read_data,
    output logic [$clog2(NUM_CH)-1:0]  grant_ch,
    output logic                       orphan_err
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int TAG_AW = $clog2(TAG_DEPTH);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_grantCh;
    logic                r_inBurst;
    logic [SIZE_W-1:0]   r_beatsLeft;
    logic [CH_W-1:0]     r_tagCh   [TAG_DEPTH];
    logic [SIZE_W-1:0]   r_tagSize [TAG_DEPTH];
    logic [TAG_AW:0]     r_wrPtr;
    logic [TAG_AW:0]     r_rdPtr;
    logic [SIZE_W-1:0]   r_retCnt;
    logic                r_orphanErr;

    logic [NUM_CH-1:0]   w_req;
    logic [CH_W-1:0]     w_pick;
    logic [CH_W-1:0]     w_idx;
    logic                w_anyReq;
    logic                w_inGrant;
    logic                w_ownRd;
    logic                w_ownWr;
    logic [SIZE_W-1:0]   w_ownSize;
    logic [SIZE_W-1:0]   w_ownLen;
    logic                w_rdAcc;
    logic                w_wrAcc;
    logic                w_tagFull;
    logic                w_tagEmpty;
    logic [CH_W-1:0]     w_headCh;
    logic [SIZE_W-1:0]   w_headSize;
    logic [SIZE_W-1:0]   w_headLen;
    logic                w_retLast;
    logic                w_pop;

    assign w_req = ch_read_req | ch_write_req;

    // Round-robin search starts just after the last owner and wraps.
    always_comb begin
        w_pick   = r_grantCh;
        w_idx    = '0;
        w_anyReq = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_W'((int'(r_grantCh) + k) % NUM_CH);
            if (!w_anyReq && w_req[w_idx]) begin
                w_pick   = w_idx;
                w_anyReq = 1'b1;
            end
        end
    end

    assign w_inGrant = (r_state == S_GRANT);
    assign w_ownRd   = ch_read_req[r_grantCh];
    assign w_ownWr   = ch_write_req[r_grantCh];
    assign w_ownSize = ch_size[int'(r_grantCh)*SIZE_W +: SIZE_W];
    assign w_ownLen  = (w_ownSize == '0) ? SIZE_W'(1) : w_ownSize;

    assign w_tagEmpty = (r_wrPtr == r_rdPtr);
    assign w_tagFull  = (r_wrPtr[TAG_AW] != r_rdPtr[TAG_AW]) &&
                        (r_wrPtr[TAG_AW-1:0] == r_rdPtr[TAG_AW-1:0]);

    // Reads only start outside an open write burst; a read beats a same-cycle write.
    always_comb begin
        ddr3_avl_read_req   = w_inGrant & ~r_inBurst & w_ownRd & ~w_tagFull;
        ddr3_avl_write_req  = w_inGrant & w_ownWr & (r_inBurst | ~w_ownRd);
        ddr3_avl_burstbegin = w_inGrant & ch_burstbegin[r_grantCh];
        ddr3_avl_size       = w_inGrant ? w_ownSize : '0;
        ddr3_avl_addr       = w_inGrant ? ch_addr[int'(r_grantCh)*ADDR_W +: ADDR_W] : '0;
        ddr3_avl_wr_data    = w_inGrant ? ch_wr_data[int'(r_grantCh)*DATA_W +: DATA_W] : '0;
        ch_ready            = '0;
        ch_ready[r_grantCh] = ddr3_avl_ready & (ddr3_avl_read_req | ddr3_avl_write_req);
    end

    assign w_rdAcc = ddr3_avl_ready & ddr3_avl_read_req;
    assign w_wrAcc = ddr3_avl_ready & ddr3_avl_write_req;

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_state     <= S_IDLE;
            r_grantCh   <= CH_W'(NUM_CH - 1);
            r_inBurst   <= 1'b0;
            r_beatsLeft <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_grantCh <= w_pick;
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_rdAcc) begin
                        r_state <= S_IDLE;
                    end else if (w_wrAcc) begin
                        // r_beatsLeft holds the beats still owed after the current one.
                        if (!r_inBurst) begin
                            if (w_ownLen == SIZE_W'(1)) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_beatsLeft <= w_ownLen - SIZE_W'(1);
                                r_inBurst   <= 1'b1;
                            end
                        end else if (r_beatsLeft == SIZE_W'(1)) begin
                            r_beatsLeft <= '0;
                            r_inBurst   <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_beatsLeft <= r_beatsLeft - SIZE_W'(1);
                        end
                    end else if (!r_inBurst && !w_ownRd && !w_ownWr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_headCh   = r_tagCh[r_rdPtr[TAG_AW-1:0]];
    assign w_headSize = r_tagSize[r_rdPtr[TAG_AW-1:0]];
    assign w_headLen  = (w_headSize == '0) ? SIZE_W'(1) : w_headSize;
    assign w_retLast  = ((r_retCnt + SIZE_W'(1)) == w_headLen);
    assign w_pop      = ddr3_avl_read_data_valid & ~w_tagEmpty & w_retLast;

    always_ff @(posedge ddr3_clk) begin
        if (w_rdAcc) begin
            r_tagCh[r_wrPtr[TAG_AW-1:0]]   <= r_grantCh;
            r_tagSize[r_wrPtr[TAG_AW-1:0]] <= w_ownSize;
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_retCnt    <= '0;
            r_orphanErr <= 1'b0;
        end else begin
            if (w_rdAcc) r_wrPtr <= r_wrPtr + 1'b1;
            if (ddr3_avl_read_data_valid) begin
                if (w_tagEmpty) begin
                    r_orphanErr <= 1'b1;
                end else if (w_retLast) begin
                    r_retCnt <= '0;
                end else begin
                    r_retCnt <= r_retCnt + SIZE_W'(1);
                end
            end
            if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_comb begin
        ch_read_data_valid = '0;
        if (ddr3_avl_read_data_valid && !w_tagEmpty) ch_read_data_valid[w_headCh] = 1'b1;
    end

    assign ch_read_data = ddr3_avl_read_data;
    assign grant_ch     = r_grantCh;
    assign orphan_err   = r_orphanErr;
endmodule
